// File: rtl/param_fir_core.sv
// -----------------------------------------------------------------------------
// param_fir_core
// Time-multiplexed FIR filter. NUM_LANES multiply-accumulate lanes each walk
// TPL = NUM_TAPS/NUM_LANES taps, so one output costs TPL MAC cycles plus one
// summing cycle. Coefficients live in a small register file that can be
// written while the core is parked in UPDATE and read back at any time.
//
// Optional build macro:
//   FIR_SAT_EN  - output narrowing saturates instead of wrapping.
//
// Ports:
//   iClk12M           clock
//   iRsn              synchronous active-low reset
//   iEnSample600k     one-cycle sample strobe
//   iFirIn            signed input sample (DATA_W)
//   iCoeffUpdateFlag  level request to enter coefficient-update mode
//   iCsnRam/iWrnRam   coefficient port chip select / write enable (active-low)
//   iAddrRam          coefficient address (ADDR_W)
//   iWtDtRam          coefficient write data (COEF_W)
//   oRdDtRam          coefficient read data, one cycle after the request
//   oFirOut           registered signed filter output (OUT_W)
//   oFirValid         one-cycle pulse when oFirOut updates
//   oBusy             high whenever the controller is not idle
//   oOverrun          sticky flag: a sample strobe was dropped
// -----------------------------------------------------------------------------
module param_fir_core #(
    parameter int NUM_TAPS  = 40,
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 3,
    parameter int COEF_W    = 16,
    parameter int OUT_W     = 16,
    parameter int ADDR_W    = 6,
    parameter int OUT_SHIFT = 0
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iEnSample600k,
    input  logic [DATA_W-1:0] iFirIn,
    input  logic              iCoeffUpdateFlag,
    input  logic              iCsnRam,
    input  logic              iWrnRam,
    input  logic [ADDR_W-1:0] iAddrRam,
    input  logic [COEF_W-1:0] iWtDtRam,
    output logic [COEF_W-1:0] oRdDtRam,
    output logic [OUT_W-1:0]  oFirOut,
    output logic              oFirValid,
    output logic              oBusy,
    output logic              oOverrun
);

    localparam int TPL    = NUM_TAPS / NUM_LANES;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(NUM_TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int KW     = (TPL > 1) ? $clog2(TPL) : 1;
    localparam int TAP_AW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    localparam logic [ADDR_W:0] TAP_LIMIT = (ADDR_W + 1)'(NUM_TAPS);
    localparam logic [KW-1:0]   K_LAST    = KW'(TPL - 1);
    localparam logic [KW-1:0]   K_ONE     = KW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        MAC    = 2'd2,
        SUM    = 2'd3
    } state_t;

    state_t                     state_r;
    state_t                     nextState_s;

    logic signed [DATA_W-1:0]   delayLine_r [NUM_TAPS];
    logic signed [COEF_W-1:0]   coef_r      [NUM_TAPS];
    logic signed [ACC_W-1:0]    acc_r       [NUM_LANES];
    logic [KW-1:0]              macCnt_r;

    logic [TAP_AW-1:0]          tapIdx_s    [NUM_LANES];
    logic signed [PROD_W-1:0]   prod_s      [NUM_LANES];
    logic signed [ACC_W-1:0]    sum_s;
    logic signed [ACC_W-1:0]    shifted_s;
    logic [OUT_W-1:0]           narrow_s;

    logic                       startMac_s;
    logic                       acceptSample_s;
    logic                       dropSample_s;
    logic                       enterUpdate_s;
    logic                       addrInRange_s;
    logic                       coefWrite_s;
    logic                       coefRead_s;

    logic [COEF_W-1:0]          rdDt_r;
    logic [OUT_W-1:0]           firOut_r;
    logic                       firValid_r;
    logic                       busy_r;
    logic                       overrun_r;

    assign oRdDtRam  = rdDt_r;
    assign oFirOut   = firOut_r;
    assign oFirValid = firValid_r;
    assign oBusy     = busy_r;
    assign oOverrun  = overrun_r;

    // Controller state register.
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state decode. A pending update request out of SUM goes straight to
    // UPDATE (the idle pass-through is collapsed) so oBusy never drops between
    // finishing the current output and servicing the update.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (iCoeffUpdateFlag) begin
                    nextState_s = UPDATE;
                end else if (iEnSample600k) begin
                    nextState_s = MAC;
                end else begin
                    nextState_s = IDLE;
                end
            end
            UPDATE: begin
                if (!iCoeffUpdateFlag) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = UPDATE;
                end
            end
            MAC: begin
                if (macCnt_r == K_LAST) begin
                    nextState_s = SUM;
                end else begin
                    nextState_s = MAC;
                end
            end
            SUM: begin
                if (iCoeffUpdateFlag) begin
                    nextState_s = UPDATE;
                end else begin
                    nextState_s = IDLE;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // Strobe classification and coefficient-port qualification.
    always_comb begin
        startMac_s     = (state_r == IDLE) && !iCoeffUpdateFlag && iEnSample600k;
        acceptSample_s = startMac_s || ((state_r == UPDATE) && iEnSample600k);
        dropSample_s   = iEnSample600k && ((state_r == MAC) || (state_r == SUM));
        enterUpdate_s  = (nextState_s == UPDATE) && (state_r != UPDATE);
        addrInRange_s  = ({1'b0, iAddrRam} < TAP_LIMIT);
        coefWrite_s    = (state_r == UPDATE) && !iCsnRam && !iWrnRam && addrInRange_s;
        coefRead_s     = !iCsnRam && iWrnRam;
    end

    // Per-lane tap selection and products; lane l owns taps l*TPL .. l*TPL+TPL-1.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            tapIdx_s[l] = TAP_AW'(l * TPL) + TAP_AW'(macCnt_r);
            prod_s[l]   = PROD_W'(delayLine_r[tapIdx_s[l]]) * PROD_W'(coef_r[tapIdx_s[l]]);
        end
    end

    // Lane reduction, output scaling and narrowing.
    always_comb begin
        sum_s = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            sum_s = sum_s + acc_r[l];
        end
        shifted_s = sum_s >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
        if (shifted_s > $signed({{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}})) begin
            narrow_s = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (shifted_s < $signed({{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}})) begin
            narrow_s = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            narrow_s = OUT_W'(shifted_s);
        end
`else
        narrow_s = OUT_W'(shifted_s);
`endif
    end

    // Delay line, lane accumulators and tap counter.
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                delayLine_r[i] <= '0;
            end
            for (int l = 0; l < NUM_LANES; l++) begin
                acc_r[l] <= '0;
            end
            macCnt_r <= '0;
        end else begin
            if (acceptSample_s) begin
                for (int i = NUM_TAPS - 1; i > 0; i--) begin
                    delayLine_r[i] <= delayLine_r[i - 1];
                end
                delayLine_r[0] <= iFirIn;
            end
            if (startMac_s) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    acc_r[l] <= '0;
                end
                macCnt_r <= '0;
            end else if (state_r == MAC) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    acc_r[l] <= acc_r[l] + ACC_W'(prod_s[l]);
                end
                // Wraps to zero after the last tap, ready for the next sample.
                macCnt_r <= (macCnt_r == K_LAST) ? '0 : macCnt_r + K_ONE;
            end
        end
    end

    // Coefficient register file with registered readback.
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coef_r[i] <= '0;
            end
            rdDt_r <= '0;
        end else begin
            if (coefWrite_s) begin
                coef_r[iAddrRam] <= iWtDtRam;
            end
            if (coefRead_s) begin
                rdDt_r <= addrInRange_s ? coef_r[iAddrRam] : '0;
            end
        end
    end

    // Registered status and result outputs.
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            firOut_r   <= '0;
            firValid_r <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            busy_r <= (nextState_s != IDLE);
            if (state_r == SUM) begin
                firOut_r   <= narrow_s;
                firValid_r <= 1'b1;
            end else begin
                firValid_r <= 1'b0;
            end
            if (enterUpdate_s) begin
                overrun_r <= 1'b0;
            end else if (dropSample_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_fir_core.sv
// -----------------------------------------------------------------------------
// tb_param_fir_core
// Directed bench for param_fir_core at default parameters. A behavioural
// convolution model produces the expected output for every accepted strobe;
// entries (value + expected arrival cycle) are queued when the strobe is
// driven and popped by a monitor when oFirValid pulses.
// -----------------------------------------------------------------------------
module tb_param_fir_core;

    localparam int TAPS    = 40;
    localparam int LATENCY = 12;

    logic        iClk12M = 1'b0;
    logic        iRsn;
    logic        iEnSample600k;
    logic [2:0]  iFirIn;
    logic        iCoeffUpdateFlag;
    logic        iCsnRam;
    logic        iWrnRam;
    logic [5:0]  iAddrRam;
    logic [15:0] iWtDtRam;
    logic [15:0] oRdDtRam;
    logic [15:0] oFirOut;
    logic        oFirValid;
    logic        oBusy;
    logic        oOverrun;

    typedef struct {
        logic [15:0] value;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   modelDelay [TAPS];
    int   modelCoef  [TAPS];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    param_fir_core dut (
        .iClk12M          (iClk12M),
        .iRsn             (iRsn),
        .iEnSample600k    (iEnSample600k),
        .iFirIn           (iFirIn),
        .iCoeffUpdateFlag (iCoeffUpdateFlag),
        .iCsnRam          (iCsnRam),
        .iWrnRam          (iWrnRam),
        .iAddrRam         (iAddrRam),
        .iWtDtRam         (iWtDtRam),
        .oRdDtRam         (oRdDtRam),
        .oFirOut          (oFirOut),
        .oFirValid        (oFirValid),
        .oBusy            (oBusy),
        .oOverrun         (oOverrun)
    );

    always #5 iClk12M = ~iClk12M;

    always @(posedge iClk12M) cyc <= cyc + 1;

    task automatic tick();
        @(posedge iClk12M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] modelOut();
        longint acc;
        acc = 0;
        for (int i = 0; i < TAPS; i++) begin
            acc += longint'(modelDelay[i]) * longint'(modelCoef[i]);
        end
`ifdef FIR_SAT_EN
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
`endif
        return acc[15:0];
    endfunction

    // accepted=1: model shifts and an output is expected LATENCY cycles later.
    task automatic strobe(input logic [2:0] v, input bit accepted);
        iFirIn        = v;
        iEnSample600k = 1'b1;
        if (accepted) begin
            for (int i = TAPS - 1; i > 0; i--) modelDelay[i] = modelDelay[i - 1];
            modelDelay[0] = int'($signed(v));
            sbq.push_back('{value: modelOut(), cyc: cyc + LATENCY});
        end
        tick();
        iEnSample600k = 1'b0;
    endtask

    task automatic writeCoef(input logic [5:0] a, input logic [15:0] d);
        iCsnRam  = 1'b0;
        iWrnRam  = 1'b0;
        iAddrRam = a;
        iWtDtRam = d;
        tick();
        iCsnRam  = 1'b1;
        iWrnRam  = 1'b1;
    endtask

    task automatic readCoef(input logic [5:0] a);
        iCsnRam  = 1'b0;
        iWrnRam  = 1'b1;
        iAddrRam = a;
        tick();
        iCsnRam  = 1'b1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sbq.size() != 0; i++) tick();
        check("drain_queue_empty", 32'(sbq.size()), 32'd0);
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest expectation.
    always @(negedge iClk12M) begin
        exp_t e;
        if (oFirValid === 1'b1) begin
            checks++;
            assert (sbq.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed=%h expected=no_output", oFirOut);
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++;
                assert (oFirOut === e.value) else begin
                    errors++;
                    $error("FAIL fir_out observed=%h expected=%h", oFirOut, e.value);
                end
                checks++;
                assert (cyc === e.cyc) else begin
                    errors++;
                    $error("FAIL valid_cycle observed=%0d expected=%0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        logic [15:0] narrowExp;
`ifdef FIR_SAT_EN
        narrowExp = 16'h7FFF;
`else
        narrowExp = 16'hFF88;
`endif
        iRsn = 1'b0; iEnSample600k = 1'b0; iFirIn = 3'd0; iCoeffUpdateFlag = 1'b0;
        iCsnRam = 1'b1; iWrnRam = 1'b1; iAddrRam = 6'd0; iWtDtRam = 16'd0;
        for (int i = 0; i < TAPS; i++) begin
            modelDelay[i] = 0;
            modelCoef[i]  = 0;
        end

        // Reset held for three cycles.
        repeat (3) tick();
        check("rst_fir_out", 32'(oFirOut), 32'd0);
        check("rst_valid", 32'(oFirValid), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_overrun", 32'(oOverrun), 32'd0);
        check("rst_rd_data", 32'(oRdDtRam), 32'd0);
        iRsn = 1'b1;
        tick();

        // Impulse response with coef[i] = i+1.
        iCoeffUpdateFlag = 1'b1;
        tick();
        check("update_busy", 32'(oBusy), 32'd1);
        for (int i = 0; i < TAPS; i++) begin
            writeCoef(6'(i), 16'(i + 1));
            modelCoef[i] = i + 1;
        end
        iCoeffUpdateFlag = 1'b0;
        tick(); tick();
        check("idle_not_busy", 32'(oBusy), 32'd0);
        strobe(3'd1, 1'b1);
        repeat (19) tick();
        for (int n = 0; n < TAPS; n++) begin
            strobe(3'd0, 1'b1);
            repeat (19) tick();
        end
        drain(40);
        check("impulse_tail_zero", 32'(oFirOut), 32'd0);

        // Narrowing: full-scale coefficients, constant input 3.
        iCoeffUpdateFlag = 1'b1;
        tick();
        for (int i = 0; i < TAPS; i++) begin
            writeCoef(6'(i), 16'h7FFF);
            modelCoef[i] = 32767;
        end
        iCoeffUpdateFlag = 1'b0;
        tick(); tick();
        for (int n = 0; n < TAPS; n++) begin
            strobe(3'd3, 1'b1);
            repeat (13) tick();
        end
        drain(40);
        check("narrow_final", 32'(oFirOut), 32'(narrowExp));

        // Overrun: second strobe five cycles after the first is dropped.
        strobe(3'd1, 1'b1);
        repeat (4) tick();
        strobe(3'd2, 1'b0);
        check("overrun_set", 32'(oOverrun), 32'd1);
        drain(40);
        check("overrun_sticky", 32'(oOverrun), 32'd1);
        iCoeffUpdateFlag = 1'b1;
        tick();
        check("overrun_cleared_on_update", 32'(oOverrun), 32'd0);
        check("update_busy2", 32'(oBusy), 32'd1);
        for (int i = 0; i < TAPS; i++) begin
            writeCoef(6'(i), 16'(i - 20));
            modelCoef[i] = i - 20;
        end
        iCoeffUpdateFlag = 1'b0;
        tick(); tick();

        // Update request and a stray write arrive at k=3 of MAC.
        strobe(3'b101, 1'b1);
        repeat (3) tick();
        iCoeffUpdateFlag = 1'b1;
        iCsnRam = 1'b0; iWrnRam = 1'b0; iAddrRam = 6'd0; iWtDtRam = 16'h5555;
        tick();
        iCsnRam = 1'b1; iWrnRam = 1'b1;
        for (int n = 0; n < 12; n++) begin
            check("busy_through_update", 32'(oBusy), 32'd1);
            tick();
        end
        drain(5);
        readCoef(6'd0);
        check("mac_write_ignored", 32'(oRdDtRam), 32'(16'hFFEC));

        // Readback in UPDATE, out-of-range read, hold with chip select high.
        writeCoef(6'd7, 16'h1234);
        modelCoef[7] = 32'h1234;
        readCoef(6'd7);
        check("readback_addr7", 32'(oRdDtRam), 32'(16'h1234));
        readCoef(6'd45);
        check("readback_addr45", 32'(oRdDtRam), 32'd0);
        iAddrRam = 6'd7;
        tick();
        check("readback_hold", 32'(oRdDtRam), 32'd0);
        iCoeffUpdateFlag = 1'b0;
        tick(); tick();
        writeCoef(6'd7, 16'hAAAA);
        readCoef(6'd7);
        check("idle_write_ignored", 32'(oRdDtRam), 32'(16'h1234));
        strobe(3'd2, 1'b1);
        drain(20);

        // Reset in the middle of MAC aborts the computation.
        strobe(3'd1, 1'b0);
        repeat (3) tick();
        iRsn = 1'b0;
        tick();
        iRsn = 1'b1;
        for (int i = 0; i < TAPS; i++) begin
            modelDelay[i] = 0;
            modelCoef[i]  = 0;
        end
        check("midmac_rst_busy", 32'(oBusy), 32'd0);
        check("midmac_rst_valid", 32'(oFirValid), 32'd0);
        check("midmac_rst_rd", 32'(oRdDtRam), 32'd0);
        repeat (14) tick();
        check("midmac_rst_out", 32'(oFirOut), 32'd0);
        readCoef(6'd7);
        check("rst_coef_cleared", 32'(oRdDtRam), 32'd0);
        drain(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
